// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM state encoding and BCD constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic bcd_digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (t > {1'b0, BCD_MAX}) begin
      // 4-bit wrap of t[3:0]+6 equals the low nibble of t+6
      s  = t[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock through a shared digit adder.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t state, state_nxt;

  logic [W-1:0]     a_q, b_q, sum_q;
  logic [IDX_W-1:0] idx;
  logic             carry, cout_q, err_q;
  logic             accept, last;
  logic [3:0]       a_d, b_d, s_d;
  logic             co_d;

  assign accept = start && (state != RUN);
  assign last   = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_d = a_q[4*i +: 4];
        b_d = b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit (
    .a  (a_d),
    .b  (b_d),
    .ci (carry),
    .s  (s_d),
    .co (co_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      carry  <= cin;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx == IDX_W'(i)) sum_q[4*i +: 4] <= s_d;
      end
      carry <= co_d;
      err_q <= err_q | bcd_digit_bad(a_d) | bcd_digit_bad(b_d);
      if (last) begin
        idx    <= '0;
        cout_q <= co_d;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed/random bench for bcd_serial_add_ctrl with a result scoreboard checked on done.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } result_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  result_t exp_q[$];
  int checks = 0;
  int fails  = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        chk("sb_sum",  32'(sum),  32'(e.sum));
        chk("sb_cout", 32'(cout), 32'(e.cout));
        chk("sb_err",  32'(err),  32'(e.err));
      end
    end
  end

  // Caller is between edges; returns at #1 after the start-accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                        input result_t e);
    a = av; b = bv; cin = c; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (sampled #1 after each edge), bounded.
  task automatic wait_done(output int edges, output int busy_n);
    edges = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy === 1'b1) busy_n++;
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int edges, bn, total;
    logic [W-1:0] ra, rb;
    logic rc;
    result_t e;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // 1234 + 5678: latency and busy width
    @(negedge clk);
    launch(16'h1234, 16'h5678, 1'b0, '{sum: 16'h6912, cout: 1'b0, err: 1'b0});
    wait_done(edges, bn);
    chk("lat_1234", 32'(edges), 32'd4);
    chk("busy_cycles", 32'(bn), 32'd4);
    repeat (3) @(posedge clk); #1;
    chk("hold_sum", 32'(sum), 32'h6912);
    chk("hold_busy", 32'(busy), 32'd0);

    // 9999 + 0001: full carry ripple
    @(negedge clk);
    launch(16'h9999, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, err: 1'b0});
    wait_done(edges, bn);
    chk("lat_9999", 32'(edges), 32'd4);

    // 9999 + 9999 + 1, then back-to-back 0005 + 0005 launched from DONE
    @(negedge clk);
    launch(16'h9999, 16'h9999, 1'b1, '{sum: 16'h9999, cout: 1'b1, err: 1'b0});
    wait_done(edges, bn);
    chk("lat_max", 32'(edges), 32'd4);
    launch(16'h0005, 16'h0005, 1'b0, '{sum: 16'h0010, cout: 1'b0, err: 1'b0});
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(edges, bn);
    chk("lat_b2b", 32'(edges), 32'd4);

    // Illegal digit: 00A0 + 0000
    @(negedge clk);
    launch(16'h00A0, 16'h0000, 1'b0, '{sum: 16'h0100, cout: 1'b0, err: 1'b1});
    wait_done(edges, bn);
    chk("lat_err", 32'(edges), 32'd4);
    @(posedge clk); #1;
    chk("err_hold", 32'(err), 32'd1);

    // Start and operand changes while busy are ignored
    @(negedge clk);
    launch(16'h1234, 16'h1111, 1'b0, '{sum: 16'h2345, cout: 1'b0, err: 1'b0});
    a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    wait_done(edges, bn);
    start = 1'b0;
    chk("lat_ignore", 32'(edges + 2), 32'd4);
    @(posedge clk); #1;
    chk("idle_after_ignore", 32'(busy), 32'd0);

    // Reset in the second RUN cycle aborts with no done pulse
    @(negedge clk);
    launch(16'h0007, 16'h0001, 1'b0, '{sum: 16'h0008, cout: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    chk("pre_rst_sum", 32'(sum), 32'h0008);
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_err",  32'(err),  32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    launch(16'h0456, 16'h0544, 1'b1, '{sum: 16'h1001, cout: 1'b0, err: 1'b0});
    wait_done(edges, bn);
    chk("lat_after_rst", 32'(edges), 32'd4);

    // Random legal operands against a decimal integer model
    for (int n = 0; n < 6; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom_range(0, 1));
      total = bcd_to_int(ra) + bcd_to_int(rb) + int'(rc);
      e.sum  = int_to_bcd(total % 10000);
      e.cout = (total >= 10000);
      e.err  = 1'b0;
      @(negedge clk);
      launch(ra, rb, rc, e);
      wait_done(edges, bn);
      chk("lat_rand", 32'(edges), 32'd4);
    end

    repeat (3) @(posedge clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
